dmem_arbiter: RTL and testbench

- Two-port arbiter and sequencer in front of the 8K-word data memory.
- Shares the single memory port between the core LSU (port 0) and the APB-side debug/loader master (port 1).
- Registers each granted command, drives the memory for exactly one cycle, and returns a registered response to the winning port.
- Rejects illegal or out-of-range accesses before they reach the memory.

---
 rtl/dmem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the data memory: grants one port per cycle,
// registers the command, drives the memory for one cycle and returns a registered response.
module dmem_arbiter #(
  parameter int DEPTH      = 8192,
  parameter int FIXED_PRIO = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,

  input  logic        i_p0_valid,
  output logic        o_p0_ready,
  input  logic [31:0] i_p0_addr,
  input  logic [31:0] i_p0_wdata,
  input  logic [3:0]  i_p0_op,
  output logic        o_p0_rvalid,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_err,

  input  logic        i_p1_valid,
  output logic        o_p1_ready,
  input  logic [31:0] i_p1_addr,
  input  logic [31:0] i_p1_wdata,
  input  logic [3:0]  i_p1_op,
  output logic        o_p1_rvalid,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_err,

  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_bmask,
  output logic        o_mem_wren,
  input  logic [31:0] i_mem_rdata
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  localparam logic [3:0] OP_LB  = 4'b0000;
  localparam logic [3:0] OP_LBU = 4'b0001;
  localparam logic [3:0] OP_LH  = 4'b0010;
  localparam logic [3:0] OP_LHU = 4'b0011;
  localparam logic [3:0] OP_LW  = 4'b0100;
  localparam logic [3:0] OP_SB  = 4'b1000;
  localparam logic [3:0] OP_SH  = 4'b1001;
  localparam logic [3:0] OP_SW  = 4'b1010;
  localparam logic [3:0] OP_NOP = 4'b1111;

  // Illegal op, out-of-range address or misalignment for the access size.
  function automatic logic access_error(input logic [3:0] op, input logic [31:0] addr);
    logic bad_op;
    logic misaligned;
    bad_op     = 1'b0;
    misaligned = 1'b0;
    case (op)
      OP_LB, OP_LBU, OP_SB: misaligned = 1'b0;
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      OP_LW, OP_SW:         misaligned = (addr[1:0] != 2'b00);
      default:              bad_op     = 1'b1;
    endcase
    return bad_op | misaligned | (addr >= ADDR_LIMIT);
  endfunction

  logic        last_p1;
  logic        grant_p0;
  logic        grant_p1;
  logic        accept;

  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_op;
  logic        sel_err;

  logic        a_vld;
  logic        a_port;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic [3:0]  a_op;
  logic        a_err;

  logic [31:0] resp_data;

  // On a tie the port that was not served last wins, unless port 0 has fixed priority.
  always_comb begin
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    if (i_p0_valid && i_p1_valid) begin
      if ((FIXED_PRIO != 0) || last_p1) begin
        grant_p0 = 1'b1;
      end else begin
        grant_p1 = 1'b1;
      end
    end else begin
      grant_p0 = i_p0_valid;
      grant_p1 = i_p1_valid;
    end
  end

  assign o_p0_ready = grant_p0;
  assign o_p1_ready = grant_p1;
  assign accept     = grant_p0 | grant_p1;

  assign sel_addr  = grant_p1 ? i_p1_addr  : i_p0_addr;
  assign sel_wdata = grant_p1 ? i_p1_wdata : i_p0_wdata;
  assign sel_op    = grant_p1 ? i_p1_op    : i_p0_op;
  assign sel_err   = access_error(sel_op, sel_addr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_p1 <= 1'b1;
    end else if (accept) begin
      last_p1 <= grant_p1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      a_vld   <= 1'b0;
      a_port  <= 1'b0;
      a_addr  <= 32'h0;
      a_wdata <= 32'h0;
      a_op    <= OP_NOP;
      a_err   <= 1'b0;
    end else begin
      a_vld <= accept;
      if (accept) begin
        a_port  <= grant_p1;
        a_addr  <= sel_addr;
        a_wdata <= sel_wdata;
        a_op    <= sel_op;
        a_err   <= sel_err;
      end
    end
  end

  // Erroring commands keep the no-op code so the memory neither writes nor reads.
  always_comb begin
    o_mem_addr  = 32'h0;
    o_mem_wdata = 32'h0;
    o_mem_bmask = OP_NOP;
    o_mem_wren  = 1'b0;
    if (a_vld) begin
      o_mem_addr  = a_addr;
      o_mem_wdata = a_wdata;
      if (!a_err) begin
        o_mem_bmask = a_op;
        o_mem_wren  = a_op[3];
      end
    end
  end

  assign resp_data = (a_vld && !a_err && !a_op[3]) ? i_mem_rdata : 32'h0;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_p0_rvalid <= 1'b0;
      o_p0_rdata  <= 32'h0;
      o_p0_err    <= 1'b0;
      o_p1_rvalid <= 1'b0;
      o_p1_rdata  <= 32'h0;
      o_p1_err    <= 1'b0;
    end else begin
      o_p0_rvalid <= a_vld & ~a_port;
      o_p0_err    <= a_vld & ~a_port & a_err;
      o_p0_rdata  <= (a_vld && !a_port) ? resp_data : 32'h0;
      o_p1_rvalid <= a_vld & a_port;
      o_p1_err    <= a_vld & a_port & a_err;
      o_p1_rdata  <= (a_vld && a_port) ? resp_data : 32'h0;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against an acceptance-ordered transaction model.
module tb_dmem_arbiter;
  localparam int DEPTH = 8192;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        p0_valid, p1_valid;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_op, p1_op;
  logic        p0_ready, p1_ready, p0_rvalid, p1_rvalid, p0_err, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_bmask;
  logic        mem_wren;

  logic        fp_p0_ready, fp_p1_ready, fp_p0_rvalid, fp_p1_rvalid, fp_p0_err, fp_p1_err;
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_mem_addr, fp_mem_wdata;
  logic [3:0]  fp_mem_bmask;
  logic        fp_mem_wren;

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(0)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_p0_valid(p0_valid), .o_p0_ready(p0_ready), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p0_op(p0_op), .o_p0_rvalid(p0_rvalid), .o_p0_rdata(p0_rdata), .o_p0_err(p0_err),
    .i_p1_valid(p1_valid), .o_p1_ready(p1_ready), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .i_p1_op(p1_op), .o_p1_rvalid(p1_rvalid), .o_p1_rdata(p1_rdata), .o_p1_err(p1_err),
    .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata), .o_mem_bmask(mem_bmask),
    .o_mem_wren(mem_wren), .i_mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.DEPTH(DEPTH), .FIXED_PRIO(1)) dut_fp (
    .i_clk(clk), .i_reset(rst),
    .i_p0_valid(p0_valid), .o_p0_ready(fp_p0_ready), .i_p0_addr(p0_addr), .i_p0_wdata(p0_wdata),
    .i_p0_op(p0_op), .o_p0_rvalid(fp_p0_rvalid), .o_p0_rdata(fp_p0_rdata), .o_p0_err(fp_p0_err),
    .i_p1_valid(p1_valid), .o_p1_ready(fp_p1_ready), .i_p1_addr(p1_addr), .i_p1_wdata(p1_wdata),
    .i_p1_op(p1_op), .o_p1_rvalid(fp_p1_rvalid), .o_p1_rdata(fp_p1_rdata), .o_p1_err(fp_p1_err),
    .o_mem_addr(fp_mem_addr), .o_mem_wdata(fp_mem_wdata), .o_mem_bmask(fp_mem_bmask),
    .o_mem_wren(fp_mem_wren), .i_mem_rdata(32'h0)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory semantics: loads extract/extend, stores merge bytes; non-load codes read junk.
  function automatic logic [31:0] ld(input logic [31:0] w, input logic [31:0] a, input logic [3:0] op);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a[1:0], 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (op)
      4'b0000: return {{24{b[7]}}, b};
      4'b0001: return {24'h0, b};
      4'b0010: return {{16{h[15]}}, h};
      4'b0011: return {16'h0, h};
      4'b0100: return w;
      default: return 32'hBAD0_BAD0;
    endcase
  endfunction

  function automatic logic [31:0] st(input logic [31:0] w, input logic [31:0] a,
                                     input logic [3:0] op, input logic [31:0] d);
    logic [31:0] r;
    r = w;
    case (op)
      4'b1000: r[{a[1:0], 3'b000} +: 8] = d[7:0];
      4'b1001: r[{a[1], 4'b0000} +: 16] = d[15:0];
      4'b1010: r = d;
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic int op_size(input logic [3:0] op);
    if (op == 4'd2 || op == 4'd3 || op == 4'd9) return 2;
    if (op == 4'd4 || op == 4'd10) return 4;
    return 1;
  endfunction

  function automatic bit is_err(input logic [3:0] op, input logic [31:0] a);
    bit legal;
    legal = (op <= 4'd4) || (op >= 4'd8 && op <= 4'd10);
    return !legal || (a >= 32'(4 * DEPTH)) || ((a % op_size(op)) != 0);
  endfunction

  logic [31:0] env_mem [DEPTH];
  logic [31:0] ref_mem [DEPTH];
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
  end
  always @(posedge clk) begin
    if (mem_wren) env_mem[mem_addr[14:2]] <= st(env_mem[mem_addr[14:2]], mem_addr, mem_bmask, mem_wdata);
  end
  assign mem_rdata = ld(env_mem[mem_addr[14:2]], mem_addr, mem_bmask);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    bit          err;
    int          acc;
  } txn_t;

  txn_t pend[$];
  bit   last1 = 1'b1;
  bit   acc0 = 1'b0;
  bit   acc1 = 1'b0;

  // Every cycle: predict grants, memory drive and responses from the accepted-transaction list.
  initial forever begin
    int   g, mi, ri;
    txn_t t;
    @(negedge clk);
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (rst) begin
      pend.delete();
      last1 = 1'b1;
      chk("rst_p0_rvalid", p0_rvalid, 0);
      chk("rst_p1_rvalid", p1_rvalid, 0);
      chk("rst_mem_wren", mem_wren, 0);
      chk("rst_mem_bmask", mem_bmask, 4'hF);
    end else begin
      mi = -1;
      ri = -1;
      foreach (pend[i]) begin
        if (pend[i].acc == cyc - 1) mi = i;
        if (pend[i].acc == cyc - 2) ri = i;
      end
      if (mi < 0) begin
        chk("mem_idle_wren", mem_wren, 0);
        chk("mem_idle_bmask", mem_bmask, 4'hF);
        chk("mem_idle_addr", mem_addr, 0);
        chk("mem_idle_wdata", mem_wdata, 0);
      end else if (pend[mi].err) begin
        chk("mem_err_wren", mem_wren, 0);
        chk("mem_err_bmask", mem_bmask, 4'hF);
      end else begin
        chk("mem_wren", mem_wren, pend[mi].op[3]);
        chk("mem_bmask", mem_bmask, pend[mi].op);
        chk("mem_addr", mem_addr, pend[mi].addr);
        chk("mem_wdata", mem_wdata, pend[mi].wdata);
      end
      chk("p0_rvalid", p0_rvalid, ri >= 0 && pend[ri].port == 0);
      chk("p1_rvalid", p1_rvalid, ri >= 0 && pend[ri].port == 1);
      chk("p0_err", p0_err, ri >= 0 && pend[ri].port == 0 && pend[ri].err);
      chk("p1_err", p1_err, ri >= 0 && pend[ri].port == 1 && pend[ri].err);
      chk("p0_rdata", p0_rdata, (ri >= 0 && pend[ri].port == 0) ? pend[ri].rdata : 32'h0);
      chk("p1_rdata", p1_rdata, (ri >= 0 && pend[ri].port == 1) ? pend[ri].rdata : 32'h0);
      while (pend.size() > 0 && pend[0].acc <= cyc - 2) void'(pend.pop_front());

      g = -1;
      if (p0_valid && p1_valid) g = last1 ? 0 : 1;
      else if (p0_valid) g = 0;
      else if (p1_valid) g = 1;
      chk("p0_ready", p0_ready, g == 0);
      chk("p1_ready", p1_ready, g == 1);
      chk("fp_p0_ready", fp_p0_ready, p0_valid);
      chk("fp_p1_ready", fp_p1_ready, p1_valid && !p0_valid);
      if (g >= 0) begin
        t.port  = g;
        t.op    = (g == 1) ? p1_op : p0_op;
        t.addr  = (g == 1) ? p1_addr : p0_addr;
        t.wdata = (g == 1) ? p1_wdata : p0_wdata;
        t.err   = is_err(t.op, t.addr);
        t.acc   = cyc;
        t.rdata = 32'h0;
        if (!t.err) begin
          if (t.op[3]) ref_mem[t.addr[14:2]] = st(ref_mem[t.addr[14:2]], t.addr, t.op, t.wdata);
          else t.rdata = ld(ref_mem[t.addr[14:2]], t.addr, t.op);
        end
        pend.push_back(t);
        last1 = (g == 1);
        acc0  = (g == 0);
        acc1  = (g == 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      p0_valid = v; p0_op = op; p0_addr = a; p0_wdata = d;
    end else begin
      p1_valid = v; p1_op = op; p1_addr = a; p1_wdata = d;
    end
  endtask

  task automatic chk_resp(input string name, input int p, input logic [31:0] exp_data, input logic exp_err);
    chk({name, "_rvalid"}, (p == 0) ? p0_rvalid : p1_rvalid, 1);
    chk({name, "_err"}, (p == 0) ? p0_err : p1_err, exp_err);
    chk({name, "_rdata"}, (p == 0) ? p0_rdata : p1_rdata, exp_data);
  endtask

  task automatic rand_req(input int p);
    logic [3:0]  op;
    logic [31:0] a;
    int          r;
    r = $urandom_range(0, 10);
    case (r)
      0, 1, 2, 3, 4: op = 4'(r);
      5, 6, 7:       op = 4'(r + 3);
      8:             op = 4'b0111;
      9:             op = 4'b1111;
      default:       op = 4'($urandom);
    endcase
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) begin
      if (op_size(op) == 2) a[0] = 1'b0;
      if (op_size(op) == 4) a[1:0] = 2'b00;
    end
    if ($urandom_range(0, 15) == 0) a = 32'h8000 + 32'($urandom_range(0, 64));
    set_req(p, 1'b1, op, a, $urandom);
  endtask

  int n0, n1;

  initial begin
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_p0_rdata", p0_rdata, 0);
    chk("reset_p1_rdata", p1_rdata, 0);
    chk("reset_mem_addr", mem_addr, 0);

    // Store, then back-to-back loads of the same word.
    set_req(0, 1'b1, 4'b1010, 32'h10, 32'hDEADBEEF);
    #1 chk("sw_ready", p0_ready, 1);
    tick(); set_req(0, 1'b1, 4'b0100, 32'h10, 32'h0);
    chk("sw_mem_wren", mem_wren, 1);
    chk("sw_mem_bmask", mem_bmask, 4'b1010);
    chk("sw_mem_addr", mem_addr, 32'h10);
    tick(); set_req(0, 1'b1, 4'b0000, 32'h10, 32'h0);
    chk_resp("sw_resp", 0, 32'h0, 1'b0);
    tick(); set_req(0, 1'b1, 4'b0001, 32'h10, 32'h0);
    chk_resp("lw_resp", 0, 32'hDEADBEEF, 1'b0);
    tick(); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk_resp("lb_resp", 0, 32'hFFFFFFEF, 1'b0);
    tick();
    chk_resp("lbu_resp", 0, 32'h000000EF, 1'b0);

    // Error cases: none may write the memory.
    tick(); set_req(1, 1'b1, 4'b0100, 32'h6, 32'h1);
    tick(); set_req(1, 1'b1, 4'b1001, 32'h8001, 32'h2);
    chk("err_wren_a", mem_wren, 0);
    tick(); set_req(1, 1'b0, 4'h0, 32'h0, 32'h0); set_req(0, 1'b1, 4'b0100, 32'h8000, 32'h3);
    chk("err_wren_b", mem_wren, 0);
    chk_resp("err_p1_lw", 1, 32'h0, 1'b1);
    tick(); set_req(0, 1'b1, 4'b0111, 32'h0, 32'h4);
    chk("err_wren_c", mem_wren, 0);
    chk_resp("err_p1_sh", 1, 32'h0, 1'b1);
    tick(); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("err_wren_d", mem_wren, 0);
    chk_resp("err_p0_lw", 0, 32'h0, 1'b1);
    tick();
    chk("err_wren_e", mem_wren, 0);
    chk_resp("err_p0_op7", 0, 32'h0, 1'b1);

    // Byte store from port 1 seen by a port 0 word load.
    tick(); set_req(1, 1'b1, 4'b1010, 32'h20, 32'h0);
    tick(); set_req(1, 1'b1, 4'b1000, 32'h20, 32'h000000A5);
    tick(); set_req(1, 1'b0, 4'h0, 32'h0, 32'h0); set_req(0, 1'b1, 4'b0100, 32'h20, 32'h0);
    tick(); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    chk_resp("sb_lw", 0, 32'h000000A5, 1'b0);

    // Async reset with one command in stage A and one in the response stage.
    tick(); set_req(0, 1'b1, 4'b0100, 32'h10, 32'h0);
    tick(); set_req(0, 1'b0, 4'h0, 32'h0, 32'h0); set_req(1, 1'b1, 4'b0100, 32'h20, 32'h0);
    tick(); set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    chk("pre_rst_p0_rvalid", p0_rvalid, 1);
    chk("pre_rst_mem_addr", mem_addr, 32'h20);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_p0_rvalid", p0_rvalid, 0);
    chk("async_rst_p1_rvalid", p1_rvalid, 0);
    chk("async_rst_p0_rdata", p0_rdata, 0);
    chk("async_rst_mem_wren", mem_wren, 0);
    chk("async_rst_mem_bmask", mem_bmask, 4'hF);
    chk("async_rst_mem_addr", mem_addr, 0);
    tick(); tick();
    rst = 1'b0;

    // Continuous contention: grants alternate starting with port 0.
    set_req(0, 1'b1, 4'b0100, 32'h10, 32'h0);
    set_req(1, 1'b1, 4'b0100, 32'h20, 32'h0);
    n0 = 0;
    n1 = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("rr_p0_ready", p0_ready, (i % 2) == 0);
      chk("rr_p1_ready", p1_ready, (i % 2) == 1);
      chk("fixed_p1_ready", fp_p1_ready, 0);
      n0 += int'(p0_rvalid);
      n1 += int'(p1_rvalid);
      tick();
    end
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      n0 += int'(p0_rvalid);
      n1 += int'(p1_rvalid);
      tick();
    end
    chk("rr_p0_resp_count", n0, 3);
    chk("rr_p1_resp_count", n1, 3);

    // Randomized traffic; requests are held until accepted or occasionally withdrawn.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if (p0_valid && !acc0) begin
        if ($urandom_range(0, 19) == 0) p0_valid = 1'b0;
      end else if ($urandom_range(0, 3) != 0) rand_req(0);
      else p0_valid = 1'b0;
      if (p1_valid && !acc1) begin
        if ($urandom_range(0, 19) == 0) p1_valid = 1'b0;
      end else if ($urandom_range(0, 2) != 0) rand_req(1);
      else p1_valid = 1'b0;
    end
    set_req(0, 1'b0, 4'h0, 32'h0, 32'h0);
    set_req(1, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
